run_sequencer: RTL and testbench
================================

RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, bus address width.
REQ-002 SHALL have parameter EntryRegAddr, default 64'h0300_0010, entry-point register address (lo word; hi word at +4).
REQ-003 SHALL have parameter RunRegAddr, default 64'h0300_0018, run-trigger register address.
REQ-004 SHALL have parameter EocRegAddr, default 64'h0300_0004, end-of-computation scratch register address.
REQ-005 SHALL have parameter PollInterval, default 16, idle cycles between EOC polls (>=1).
REQ-006 SHALL have ports: clk_i in 1 clock; rst_i in 1 synchronous active-high reset; one clock domain only.
REQ-007 SHALL have ports: start_i in 1 start pulse; entry_i in 64 entry point, sampled on accepted start.
REQ-008 SHALL have ports: req_o out 1; addr_o out AddrWidth; we_o out 1; wdata_o out 32; gnt_i in 1.
REQ-009 SHALL have ports: rvalid_i in 1; rdata_i in 32; rerr_i in 1.
REQ-010 SHALL have ports: busy_o out 1; done_o out 1; exit_code_o out 31; err_o out 1.

Function
REQ-011 SHALL implement FSM IDLE -> WR_LO -> WR_HI -> WR_RUN -> WAIT -> RD_EOC -> (WAIT | DONE); ERROR absorbing until start.
REQ-012 SHALL accept start_i only in IDLE, DONE or ERROR; start_i in other states is ignored.
REQ-013 SHALL on accepted start latch entry_i, clear done_o/err_o/exit_code_o, and enter WR_LO the next cycle.
REQ-014 SHALL in WR_LO write entry[31:0] to EntryRegAddr; WR_HI write entry[63:32] to EntryRegAddr+4; WR_RUN write 32'h1 to RunRegAddr.
REQ-015 SHALL hold req_o, addr_o, we_o, wdata_o stable from assertion until the cycle gnt_i is high; req_o deasserts the cycle after the grant.
REQ-016 SHALL keep at most one transaction outstanding; the next request is issued no earlier than the cycle after rvalid_i.
REQ-017 SHALL treat rvalid_i high together with rerr_i high as an error: go to ERROR, assert err_o.
REQ-018 SHALL in WAIT count PollInterval cycles then enter RD_EOC issuing a read (we_o=0, wdata_o=0) of EocRegAddr.
REQ-019 SHALL on read response with rdata_i[0]=0 return to WAIT, restarting the interval counter from 0.
REQ-020 SHALL on read response with rdata_i[0]=1 load exit_code_o=rdata_i[31:1], assert done_o, enter DONE.
REQ-021 SHALL assert busy_o in every state except IDLE, DONE, ERROR.
REQ-022 SHALL hold done_o, exit_code_o, err_o as levels until the next accepted start or reset.
REQ-023 SHALL ignore rvalid_i when no transaction is outstanding.
REQ-024 SHALL drive req_o=0 in IDLE, WAIT, DONE, ERROR.

Reset
REQ-025 SHALL on rst_i at a clock edge enter IDLE from any state, including mid-transaction, abandoning any outstanding access.
REQ-026 SHALL reset req_o=0, addr_o=0, we_o=0, wdata_o=0, busy_o=0, done_o=0, exit_code_o=0, err_o=0, all counters 0.

Configuration
REQ-027 SHALL, with RUN_SEQUENCER_TIMEOUT_EN defined, add parameter TimeoutPolls (default 1024) and an EOC poll counter; reaching TimeoutPolls reads with rdata_i[0]=0 enters ERROR with err_o=1.
REQ-028 SHALL, without RUN_SEQUENCER_TIMEOUT_EN, poll indefinitely, with no poll counter or TimeoutPolls parameter present.

Verification
REQ-029 SHALL cover: start with entry_i=64'h8000_0000_0000_1000, zero-wait grants -> writes 32'h0000_1000@EntryRegAddr, 32'h8000_0000@+4, 32'h1@RunRegAddr, in order.
REQ-030 SHALL cover: gnt_i delayed 5 cycles on WR_HI -> req_o/addr_o/wdata_o stable all 6 cycles, single write observed.
REQ-031 SHALL cover: EOC reads return 0,0,32'h0000_0007 -> three reads spaced >=PollInterval idle cycles, done_o=1, exit_code_o=3, busy_o=0.
REQ-032 SHALL cover: rerr_i=1 on WR_RUN response -> ERROR, err_o=1, no further requests; new start restarts at WR_LO with err_o cleared.
REQ-033 SHALL cover: rst_i asserted during RD_EOC with request pending -> next cycle IDLE, all outputs at reset values; late rvalid_i ignored.
REQ-034 SHALL cover (TIMEOUT_EN, TimeoutPolls=4): EOC always 0 -> exactly 4 reads, then err_o=1, done_o=0.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: loads an entry point, triggers a run, polls EOC for completion.
// Define RUN_SEQUENCER_TIMEOUT_EN to bound the number of EOC polls (TimeoutPolls).
module run_sequencer #(
  parameter int          AddrWidth    = 64,
  parameter logic [63:0] EntryRegAddr = 64'h0300_0010,
  parameter logic [63:0] RunRegAddr   = 64'h0300_0018,
  parameter logic [63:0] EocRegAddr   = 64'h0300_0004,
  parameter int          PollInterval = 16
`ifdef RUN_SEQUENCER_TIMEOUT_EN
  ,
  parameter int          TimeoutPolls = 1024
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [63:0]          entry_i,
  output logic                 req_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 we_o,
  output logic [31:0]          wdata_o,
  input  logic                 gnt_i,
  input  logic                 rvalid_i,
  input  logic [31:0]          rdata_i,
  input  logic                 rerr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [30:0]          exit_code_o,
  output logic                 err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LO, S_WR_HI, S_WR_RUN,
    S_WAIT, S_RD_EOC, S_DONE, S_ERROR
  } state_e;

  localparam int CntW = $clog2(PollInterval + 1);
  localparam logic [AddrWidth-1:0] EntryLo = EntryRegAddr[AddrWidth-1:0];
  localparam logic [AddrWidth-1:0] EntryHi = EntryLo + AddrWidth'(4);
  localparam logic [AddrWidth-1:0] RunA = RunRegAddr[AddrWidth-1:0];
  localparam logic [AddrWidth-1:0] EocA = EocRegAddr[AddrWidth-1:0];

  state_e               state, state_d;
  logic [31:0]          hi, hi_d;
  logic                 req_d, we_d;
  logic [AddrWidth-1:0] addr_d;
  logic [31:0]          wdata_d;
  logic                 outst, outst_d;
  logic [CntW-1:0]      cnt, cnt_d;
  logic                 done_d, err_d;
  logic [30:0]          code_d;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutPolls + 1);
  logic [TW-1:0]        polls, polls_d;
`endif

  assign busy_o = !(state inside {S_IDLE, S_DONE, S_ERROR});

  always_comb begin
    state_d = state;
    hi_d    = hi;
    req_d   = req_o;
    addr_d  = addr_o;
    we_d    = we_o;
    wdata_d = wdata_o;
    outst_d = outst;
    cnt_d   = cnt;
    done_d  = done_o;
    code_d  = exit_code_o;
    err_d   = err_o;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
    polls_d = polls;
`endif
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          hi_d    = entry_i[63:32];
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = '0;
          cnt_d   = '0;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
          polls_d = '0;
`endif
          state_d = S_WR_LO;
          req_d   = 1'b1;
          addr_d  = EntryLo;
          we_d    = 1'b1;
          wdata_d = entry_i[31:0];
        end
      end
      S_WAIT: begin
        if (cnt == CntW'(PollInterval - 1)) begin
          cnt_d   = '0;
          state_d = S_RD_EOC;
          req_d   = 1'b1;
          addr_d  = EocA;
          we_d    = 1'b0;
          wdata_d = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        // a grant closes the request phase; the response is only
        // honoured once the access is outstanding
        if (req_o && gnt_i) begin
          req_d   = 1'b0;
          outst_d = 1'b1;
        end else if (outst && rvalid_i) begin
          outst_d = 1'b0;
          if (rerr_i) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            case (state)
              S_WR_LO: begin
                state_d = S_WR_HI;
                req_d   = 1'b1;
                addr_d  = EntryHi;
                wdata_d = hi;
              end
              S_WR_HI: begin
                state_d = S_WR_RUN;
                req_d   = 1'b1;
                addr_d  = RunA;
                wdata_d = 32'h1;
              end
              S_WR_RUN: begin
                state_d = S_WAIT;
                cnt_d   = '0;
              end
              S_RD_EOC: begin
                if (rdata_i[0]) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  code_d  = rdata_i[31:1];
                end else begin
`ifdef RUN_SEQUENCER_TIMEOUT_EN
                  if (polls == TW'(TimeoutPolls - 1)) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                  end else begin
                    polls_d = polls + 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                  end
`else
                  state_d = S_WAIT;
                  cnt_d   = '0;
`endif
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      hi          <= '0;
      req_o       <= 1'b0;
      addr_o      <= '0;
      we_o        <= 1'b0;
      wdata_o     <= '0;
      outst       <= 1'b0;
      cnt         <= '0;
      done_o      <= 1'b0;
      exit_code_o <= '0;
      err_o       <= 1'b0;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
      polls       <= '0;
`endif
    end else begin
      state       <= state_d;
      hi          <= hi_d;
      req_o       <= req_d;
      addr_o      <= addr_d;
      we_o        <= we_d;
      wdata_o     <= wdata_d;
      outst       <= outst_d;
      cnt         <= cnt_d;
      done_o      <= done_d;
      exit_code_o <= code_d;
      err_o       <= err_d;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
      polls       <= polls_d;
`endif
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: randomized bus slave plus transaction-level reference
// model for the run_sequencer write/trigger/poll sequence.
module tb_run_sequencer;
  localparam int PI = 4;
  localparam logic [63:0] ENTRY = 64'h0300_0010;
  localparam logic [63:0] RUN   = 64'h0300_0018;
  localparam logic [63:0] EOC   = 64'h0300_0004;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] entry;
  logic        req, we, gnt, rvalid, rerr;
  logic [63:0] addr;
  logic [31:0] wdata, rdata;
  logic        busy, done, err;
  logic [30:0] code;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef RUN_SEQUENCER_TIMEOUT_EN
  run_sequencer #(.PollInterval(PI), .TimeoutPolls(4)) dut (
`else
  run_sequencer #(.PollInterval(PI)) dut (
`endif
    .clk_i(clk), .rst_i(rst), .start_i(start), .entry_i(entry),
    .req_o(req), .addr_o(addr), .we_o(we), .wdata_o(wdata),
    .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata), .rerr_i(rerr),
    .busy_o(busy), .done_o(done), .exit_code_o(code), .err_o(err)
  );

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          held;
    int          rise;
    int          rvc;
    bit          stable;
    bit          overlap;
  } txn_t;

  txn_t log_q[$];
  int gmin = 0, gmax = 0, rmin = 0, rmax = 0;
  logic [63:0] ov_addr = '0;
  int ov_delay = -1;
  int err_at = -1;
  logic [31:0] eoc_vals[32];
  int eoc_n = 0, eoc_start = 0;
  int reads_total = 0;
  int spur_req = 0, spur_done = 0;

  // bus slave: random grant/response latency, logs every granted access
  initial begin : slave
    bit in_req, pend, perr;
    int gw, rw, idx, k;
    logic [31:0] pdata;
    txn_t t;
    in_req = 0; pend = 0; perr = 0; gw = 0; rw = 0; idx = 0; pdata = '0;
    gnt = 0; rvalid = 0; rerr = 0; rdata = '0;
    forever begin
      @(negedge clk);
      gnt = 0; rvalid = 0; rerr = 0; rdata = '0;
      if (rst) begin
        in_req = 0; pend = 0;
      end else begin
        if (spur_req != spur_done) begin
          spur_done++;
          rvalid = 1; rdata = 32'h7;
        end else if (pend) begin
          if (rw == 0) begin
            rvalid = 1; rdata = pdata; rerr = perr; pend = 0;
            log_q[idx].rvc = cyc;
          end else rw--;
        end
        if (req) begin
          if (!in_req) begin
            in_req = 1;
            t.addr = addr; t.we = we; t.wdata = wdata;
            t.held = 0; t.rise = cyc; t.rvc = 0;
            t.stable = 1; t.overlap = 0;
            gw = (addr == ov_addr && ov_delay >= 0) ? ov_delay
                 : $urandom_range(gmax, gmin);
          end else if (addr !== t.addr || we !== t.we || wdata !== t.wdata)
            t.stable = 0;
          t.held++;
          if (pend) t.overlap = 1;
          if (gw == 0) begin
            gnt = 1; in_req = 0;
            idx = log_q.size();
            log_q.push_back(t);
            perr = (idx == err_at);
            pdata = '0;
            if (!t.we) begin
              k = reads_total - eoc_start;
              pdata = (k < eoc_n) ? eoc_vals[k] : 32'h0;
              reads_total++;
            end
            pend = 1;
            rw = $urandom_range(rmax, rmin);
          end else gw--;
        end else in_req = 0;
      end
    end
  end

  // reference model: the access list for one run
  function automatic logic [96:0] exp_txn(input logic [63:0] e, input int j);
    if (j == 0) return {ENTRY, 1'b1, e[31:0]};
    if (j == 1) return {ENTRY + 64'd4, 1'b1, e[63:32]};
    if (j == 2) return {RUN, 1'b1, 32'h1};
    return {EOC, 1'b0, 32'h0};
  endfunction

  task automatic pulse_start(input logic [63:0] e);
    @(negedge clk);
    start = 1; entry = e;
    @(negedge clk);
    start = 0; entry = {$urandom, $urandom};
  endtask

  task automatic wait_end(input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (done || err) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL end_timeout: done=%0b err=%0b after %0d cycles, need one high",
               done, err, lim);
    end
  endtask

  task automatic set_eoc(input int n, input logic [31:0] last);
    eoc_start = reads_total;
    eoc_n = n + 1;
    for (int i = 0; i < n; i++) eoc_vals[i] = {$urandom_range(65535, 0), 16'h0} & 32'hFFFF_FFFE;
    eoc_vals[n] = last;
  endtask

  task automatic test_reset;
    rst = 1; start = 0; entry = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req, we, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req/we/busy/done/err=%b need 00000",
               {req, we, busy, done, err});
    end
    checks++;
    if (addr !== 64'h0 || wdata !== 32'h0 || code !== 31'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h code=%h need zeros", addr, wdata, code);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [63:0] e;
    int b;
    e = 64'h8000_0000_0000_1000;
    gmin = 0; gmax = 0; rmin = 0; rmax = 0;
    set_eoc(0, 32'h1);
    b = log_q.size();
    pulse_start(e);
    wait_end(300);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({log_q[b+j].addr, log_q[b+j].we, log_q[b+j].wdata} !== exp_txn(e, j)) begin
        errors++;
        $display("FAIL basic_write%0d: got %h/%0b/%h need %h", j, log_q[b+j].addr,
                 log_q[b+j].we, log_q[b+j].wdata, exp_txn(e, j));
      end
    end
    checks++;
    if (log_q.size() - b != 4 || done !== 1'b1 || code !== 31'h0) begin
      errors++;
      $display("FAIL basic_end: txns=%0d done=%0b code=%h need 4/1/0",
               log_q.size() - b, done, code);
    end
  endtask

  task automatic test_grant_delay;
    logic [63:0] e;
    int b, n;
    e = {$urandom, $urandom};
    ov_addr = ENTRY + 64'd4; ov_delay = 5;
    set_eoc(0, 32'h3);
    b = log_q.size();
    pulse_start(e);
    wait_end(300);
    n = 0;
    for (int j = b; j < log_q.size(); j++) if (log_q[j].addr == ENTRY + 64'd4) n++;
    checks++;
    if (log_q[b+1].held != 6 || !log_q[b+1].stable) begin
      errors++;
      $display("FAIL hold_stable: held=%0d stable=%0b need 6/1",
               log_q[b+1].held, log_q[b+1].stable);
    end
    checks++;
    if (n != 1 || log_q[b+1].wdata !== e[63:32]) begin
      errors++;
      $display("FAIL hold_single: writes=%0d wdata=%h need 1/%h", n, log_q[b+1].wdata, e[63:32]);
    end
    checks++;
    if (done !== 1'b1 || code !== 31'h1) begin
      errors++;
      $display("FAIL hold_end: done=%0b code=%h need 1/1", done, code);
    end
    ov_delay = -1;
  endtask

  task automatic test_polls;
    int b;
    gmin = 0; gmax = 2; rmin = 0; rmax = 2;
    eoc_start = reads_total; eoc_n = 3;
    eoc_vals[0] = 32'h0; eoc_vals[1] = 32'h0; eoc_vals[2] = 32'h7;
    b = log_q.size();
    pulse_start({$urandom, $urandom});
    wait_end(500);
    checks++;
    if (log_q.size() - b != 6) begin
      errors++;
      $display("FAIL polls_count: txns=%0d need 6", log_q.size() - b);
    end else begin
      for (int j = 3; j < 6; j++) begin
        checks++;
        if (log_q[b+j].addr !== EOC || log_q[b+j].we !== 1'b0 ||
            log_q[b+j].rise - log_q[b+j-1].rvc - 1 < PI) begin
          errors++;
          $display("FAIL polls_read%0d: addr=%h we=%0b gap=%0d need %h/0/>=%0d", j,
                   log_q[b+j].addr, log_q[b+j].we,
                   log_q[b+j].rise - log_q[b+j-1].rvc - 1, EOC, PI);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || code !== 31'h3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL polls_end: done=%0b code=%h busy=%0b need 1/3/0", done, code, busy);
    end
  endtask

  task automatic test_random;
    logic [63:0] e;
    logic [31:0] last;
    int b, z, bad;
    for (int it = 0; it < 8; it++) begin
      e = {$urandom, $urandom};
      gmin = 0; gmax = 3; rmin = 0; rmax = 3;
      z = $urandom_range(3, 0);
      last = $urandom | 32'h1;
      set_eoc(z, last);
      b = log_q.size();
      pulse_start(e);
      @(negedge clk);
      pulse_start(~e);
      wait_end(800);
      checks++;
      if (log_q.size() - b != 4 + z) begin
        errors++;
        $display("FAIL rand%0d_count: txns=%0d need %0d", it, log_q.size() - b, 4 + z);
      end else begin
        bad = 0;
        for (int j = 0; j < 4 + z; j++)
          if ({log_q[b+j].addr, log_q[b+j].we, log_q[b+j].wdata} !== exp_txn(e, j) ||
              !log_q[b+j].stable || log_q[b+j].overlap) bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL rand%0d_txns: %0d bad accesses need 0", it, bad);
        end
      end
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || code !== last[31:1]) begin
        errors++;
        $display("FAIL rand%0d_end: done=%0b err=%0b code=%h need 1/0/%h",
                 it, done, err, code, last[31:1]);
      end
    end
  endtask

  task automatic test_error;
    logic [63:0] e;
    int n0;
    gmin = 0; gmax = 1; rmin = 0; rmax = 1;
    set_eoc(0, 32'h1);
    err_at = log_q.size() + 2;
    pulse_start({$urandom, $urandom});
    wait_end(300);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL error_state: err=%0b done=%0b busy=%0b need 1/0/0", err, done, busy);
    end
    n0 = log_q.size();
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() != n0 || req !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL error_quiet: new txns=%0d req=%0b err=%0b need 0/0/1",
               log_q.size() - n0, req, err);
    end
    err_at = -1;
    e = {$urandom, $urandom};
    set_eoc(1, 32'h5);
    pulse_start(e);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL error_restart: err=%0b busy=%0b need 0/1", err, busy);
    end
    wait_end(500);
    checks++;
    if ({log_q[n0].addr, log_q[n0].we, log_q[n0].wdata} !== exp_txn(e, 0) ||
        done !== 1'b1 || code !== 31'h2) begin
      errors++;
      $display("FAIL error_rerun: first=%h/%h done=%0b code=%h need %h/1/2",
               log_q[n0].addr, log_q[n0].wdata, done, code, exp_txn(e, 0));
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    ov_addr = EOC; ov_delay = 30;
    gmin = 0; gmax = 0; rmin = 0; rmax = 0;
    set_eoc(0, 32'h1);
    pulse_start({$urandom, $urandom});
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (req && !we) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstmid_read: EOC request not seen, need one");
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({req, we, busy, done, err} !== 5'b0 || addr !== 64'h0 ||
        wdata !== 32'h0 || code !== 31'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: req/we/busy/done/err=%b addr=%h need zeros",
               {req, we, busy, done, err}, addr);
    end
    rst = 0;
    ov_delay = -1;
    spur_req++;
    repeat (5) @(negedge clk);
    checks++;
    if ({req, busy, done, err} !== 4'b0 || code !== 31'h0) begin
      errors++;
      $display("FAIL rstmid_late: req/busy/done/err=%b code=%h need zeros",
               {req, busy, done, err}, code);
    end
  endtask

`ifdef RUN_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout;
    int r0;
    gmin = 0; gmax = 1; rmin = 0; rmax = 1;
    eoc_start = reads_total; eoc_n = 0;
    r0 = reads_total;
    pulse_start({$urandom, $urandom});
    wait_end(800);
    checks++;
    if (reads_total - r0 != 4 || err !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_end: reads=%0d err=%0b done=%0b need 4/1/0",
               reads_total - r0, err, done);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_grant_delay;
    test_polls;
    test_random;
    test_error;
    test_reset_mid;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
